loop_data_logger: RTL and testbench

Snapshot logger for the closed-loop stage in the DAC_CLK domain. It consumes the error and feedback-step words produced downstream of the error-signal generator. It decimates them on the step-sync strobe and buffers {err, step} records in a FIFO, so the CPU can read a coherent, gap-free record stream through varset registers instead of sampling free-running values.

---
 rtl/lgsm_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 82 ++++++++
 rtl/loop_data_logger.sv | 164 ++++++++++++++++
 tb/tb_loop_data_logger.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lgsm_pkg.sv
// Shared types and control-bit positions for the closed-loop data logger.
package lgsm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } log_state_t;

   localparam int CTRL_ARM  = 0;
   localparam int CTRL_CONT = 1;
   localparam int CTRL_CLR  = 2;

   function automatic logic is_rise(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: RAM plus a prefetch head register, with
// synchronous flush. o_count covers both the RAM and the head register.
module sync_fifo_fwft #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 256
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_head_vld;
   logic [WIDTH-1:0] r_head;

   logic             w_full;
   logic             w_pop;
   logic             w_wr_acc;
   logic [CW-1:0]    w_ram_cnt;
   logic             w_load;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_pop     = i_rd & r_head_vld & ~i_flush;
   // A full FIFO still accepts a write when the head is popped in the same cycle.
   assign w_wr_acc  = i_wr & ~i_flush & (~w_full | w_pop);
   assign w_ram_cnt = r_count - {{AW{1'b0}}, r_head_vld};
   assign w_load    = (w_ram_cnt != '0) & (~r_head_vld | w_pop);

   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head_vld <= 1'b0;
         r_head     <= '0;
      end else if (i_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head_vld <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_load) begin
            r_head   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_head_vld <= w_load | (r_head_vld & ~w_pop);
         case ({w_wr_acc, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_head;
   assign o_valid   = r_head_vld;
   assign o_full    = w_full;
   assign o_count   = r_count;

endmodule

// File: rtl/loop_data_logger.sv
// Step-sync decimating snapshot logger: buffers {err, step} records in a
// show-ahead FIFO for gap-free CPU readout; single-shot or continuous capture.
module loop_data_logger
   import lgsm_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_trig,
   input  logic signed [DATA_W-1:0]   i_err,
   input  logic signed [DATA_W-1:0]   i_step,
   input  logic [31:0]                i_ctrl,
   input  logic [31:0]                i_dec,
   input  logic [31:0]                i_len,
   input  logic                       i_rd,
   output logic signed [DATA_W-1:0]   o_rd_err,
   output logic signed [DATA_W-1:0]   o_rd_step,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [1:0]                 o_state,
   output logic                       o_overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   log_state_t          r_state;
   log_state_t          w_state_nxt;
   logic                r_arm_prev;
   logic                r_clr_prev;
   logic [15:0]         r_dec_cfg;
   logic [15:0]         r_dec_cnt;
   logic [CW-1:0]       r_len;
   logic [CW-1:0]       r_wr_cnt;
   logic                r_overflow;

   logic                w_arm_edge;
   logic                w_clr_edge;
   logic                w_flush;
   logic                w_cont;
   logic                w_wr;
   logic                w_pop;
   logic                w_drop;
   logic                w_last_wr;
   logic                w_last_pop;
   logic                w_valid;
   logic                w_full;
   logic [CW-1:0]       w_count;
   logic [2*DATA_W-1:0] w_rd_data;
   logic                w_unused_bits;

   // Zero or out-of-range lengths mean "fill the whole FIFO".
   function automatic logic [CW-1:0] clamp_len(input logic [31:0] len);
      logic [CW-1:0] l;
      l = len[CW-1:0];
      if (l == '0 || l > CW'(DEPTH)) begin
         return CW'(DEPTH);
      end
      return l;
   endfunction

   assign w_arm_edge = is_rise(i_ctrl[CTRL_ARM], r_arm_prev);
   assign w_clr_edge = is_rise(i_ctrl[CTRL_CLR], r_clr_prev);
   assign w_flush    = w_arm_edge | w_clr_edge;
   assign w_cont     = i_ctrl[CTRL_CONT];

   assign w_wr       = (r_state == CAPTURE) & i_trig & (r_dec_cnt == '0) & ~w_flush;
   assign w_pop      = i_rd & w_valid;
   assign w_drop     = w_wr & w_full & ~w_pop;
   assign w_last_wr  = w_wr & ~w_cont & ((r_wr_cnt + CW'(1)) >= r_len);
   assign w_last_pop = w_pop & (w_count == CW'(1));

   assign w_unused_bits = ^{i_ctrl[31:3], i_dec[31:16], i_len[31:CW]};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Clear outranks arm; both override whatever the current state wants.
   always_comb begin
      w_state_nxt = r_state;
      if (w_clr_edge) begin
         w_state_nxt = IDLE;
      end else if (w_arm_edge) begin
         w_state_nxt = CAPTURE;
      end else begin
         case (r_state)
            CAPTURE: if (w_last_wr)  w_state_nxt = DONE;
            DONE:    if (w_last_pop) w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      o_state = r_state;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_arm_prev <= 1'b0;
         r_clr_prev <= 1'b0;
         r_dec_cfg  <= '0;
         r_dec_cnt  <= '0;
         r_len      <= '0;
         r_wr_cnt   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_arm_prev <= i_ctrl[CTRL_ARM];
         r_clr_prev <= i_ctrl[CTRL_CLR];
         if (w_clr_edge) begin
            r_overflow <= 1'b0;
         end else if (w_arm_edge) begin
            r_overflow <= 1'b0;
            r_dec_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_dec_cfg  <= i_dec[15:0];
            r_len      <= clamp_len(i_len);
         end else begin
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
            if (r_state == CAPTURE && i_trig) begin
               if (r_dec_cnt == '0) begin
                  r_dec_cnt <= r_dec_cfg;
                  if (!w_cont) begin
                     r_wr_cnt <= r_wr_cnt + CW'(1);
                  end
               end else begin
                  r_dec_cnt <= r_dec_cnt - 16'd1;
               end
            end
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (2*DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_flush   (w_flush),
      .i_wr      (w_wr),
      .i_wr_data ({i_err, i_step}),
      .i_rd      (i_rd),
      .o_rd_data (w_rd_data),
      .o_valid   (w_valid),
      .o_full    (w_full),
      .o_count   (w_count)
   );

   assign o_rd_err   = w_rd_data[2*DATA_W-1:DATA_W];
   assign o_rd_step  = w_rd_data[DATA_W-1:0];
   assign o_valid    = w_valid;
   assign o_count    = w_count;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_loop_data_logger.sv
// Bench for loop_data_logger: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_loop_data_logger;

   localparam int DEPTH = 256;
   localparam int DW    = 32;
   localparam int CW    = 9;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 trig;
   logic                 rd;
   logic [31:0]          ctrl;
   logic [31:0]          dec;
   logic [31:0]          len;
   logic signed [DW-1:0] err;
   logic signed [DW-1:0] step;
   logic signed [DW-1:0] rd_err;
   logic signed [DW-1:0] rd_step;
   logic                 valid;
   logic [CW-1:0]        count;
   logic [1:0]           state;
   logic                 ovf;

   int n_tot  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   loop_data_logger #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_trig     (trig),
      .i_err      (err),
      .i_step     (step),
      .i_ctrl     (ctrl),
      .i_dec      (dec),
      .i_len      (len),
      .i_rd       (rd),
      .o_rd_err   (rd_err),
      .o_rd_step  (rd_step),
      .o_valid    (valid),
      .o_count    (count),
      .o_state    (state),
      .o_overflow (ovf)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, $signed(act), $signed(exp));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic                 rst_n;
      logic [2:0]           ctrl;
      logic                 trig;
      logic signed [31:0]   err;
      logic signed [31:0]   step;
      logic                 rd;
      int                   cnt;
      logic                 vld;
      logic [1:0]           st;
      logic                 ovf;
      logic                 chk_data;
      logic signed [31:0]   e_err;
      logic signed [31:0]   e_step;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [2:0] c, input logic t,
                               input int e, input int s, input logic rdv, input int cn,
                               input logic v, input logic [1:0] st, input logic ov,
                               input logic cd, input int ee, input int es);
      vec_t x;
      x.rst_n = r;  x.ctrl = c;  x.trig = t;  x.err = e;  x.step = s;  x.rd = rdv;
      x.cnt = cn;   x.vld = v;   x.st = st;   x.ovf = ov; x.chk_data = cd;
      x.e_err = ee; x.e_step = es;
      return x;
   endfunction

   // Reference model: records are visible one edge after being written and no
   // earlier than the pop of their predecessor.
   typedef struct {
      logic [31:0] err;
      logic [31:0] step;
      int          w;
   } rec_t;

   rec_t     m_q[$];
   int       m_t = 0;
   int       m_vis = 0;
   int       m_state = 0;
   bit       m_ovf = 0;
   bit [2:0] m_prev = 0;
   int       m_trigs = 0;
   int       m_dec = 0;
   int       m_len = 0;
   int       m_wcnt = 0;

   function automatic int clampm(input logic [31:0] l);
      int v;
      v = int'(l & 32'(2*DEPTH-1));
      return (v == 0 || v > DEPTH) ? DEPTH : v;
   endfunction

   function automatic bit m_valid_after(input int t);
      return (m_q.size() > 0) && (m_vis <= t);
   endfunction

   task automatic model_edge();
      bit arm_e, clr_e, pop;
      int st0;
      rec_t r;
      m_t++;
      if (!rst_n) begin
         m_q.delete(); m_state = 0; m_ovf = 0; m_prev = 0;
         m_trigs = 0; m_dec = 0; m_len = 0; m_wcnt = 0;
         return;
      end
      arm_e  = ctrl[0] && !m_prev[0];
      clr_e  = ctrl[2] && !m_prev[2];
      m_prev = ctrl[2:0];
      pop    = rd && m_valid_after(m_t - 1);
      if (clr_e) begin
         m_q.delete(); m_ovf = 0; m_state = 0;
      end else if (arm_e) begin
         m_q.delete(); m_ovf = 0; m_trigs = 0; m_wcnt = 0;
         m_dec = int'(dec[15:0]); m_len = clampm(len); m_state = 1;
      end else begin
         st0 = m_state;
         if (pop) begin
            void'(m_q.pop_front());
            if (m_q.size() > 0) m_vis = (m_q[0].w + 1 > m_t) ? m_q[0].w + 1 : m_t;
            if (st0 == 2 && m_q.size() == 0) m_state = 0;
         end
         if (st0 == 1 && trig) begin
            if (m_trigs % (m_dec + 1) == 0) begin
               if (m_q.size() >= DEPTH) m_ovf = 1;
               else begin
                  if (m_q.size() == 0) m_vis = m_t + 1;
                  r.err = err; r.step = step; r.w = m_t;
                  m_q.push_back(r);
               end
               m_wcnt++;
               if (!ctrl[1] && m_wcnt >= m_len) m_state = 2;
            end
            m_trigs++;
         end
      end
   endtask

   vec_t     tbl[15];
   logic [2:0] rc;
   int       pick;

   initial begin
      rst_n = 1'b0; trig = 1'b0; rd = 1'b0; ctrl = '0; dec = '0; len = 32'd4;
      err = '0; step = '0;

      // Single-shot, dec 0, len 4
      tbl[0]  = mk(0, 3'b000, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      tbl[1]  = mk(1, 3'b001, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0);
      tbl[2]  = mk(1, 3'b001, 1, 1, -1, 0, 1, 0, 1, 0, 0, 0,  0);
      tbl[3]  = mk(1, 3'b001, 0, 0,  0, 0, 1, 1, 1, 0, 1, 1, -1);
      tbl[4]  = mk(1, 3'b001, 1, 2, -2, 0, 2, 1, 1, 0, 1, 1, -1);
      tbl[5]  = mk(1, 3'b001, 0, 0,  0, 0, 2, 1, 1, 0, 1, 1, -1);
      tbl[6]  = mk(1, 3'b001, 1, 3, -3, 0, 3, 1, 1, 0, 1, 1, -1);
      tbl[7]  = mk(1, 3'b001, 0, 0,  0, 0, 3, 1, 1, 0, 1, 1, -1);
      tbl[8]  = mk(1, 3'b001, 1, 4, -4, 0, 4, 1, 2, 0, 1, 1, -1);
      tbl[9]  = mk(1, 3'b001, 1, 5, -5, 0, 4, 1, 2, 0, 1, 1, -1);
      tbl[10] = mk(1, 3'b001, 0, 0,  0, 1, 3, 1, 2, 0, 1, 2, -2);
      tbl[11] = mk(1, 3'b001, 0, 0,  0, 1, 2, 1, 2, 0, 1, 3, -3);
      tbl[12] = mk(1, 3'b001, 0, 0,  0, 1, 1, 1, 2, 0, 1, 4, -4);
      tbl[13] = mk(1, 3'b001, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  0);
      tbl[14] = mk(1, 3'b001, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  0);

      for (int i = 0; i < 15; i++) begin
         rst_n = tbl[i].rst_n; ctrl = {29'd0, tbl[i].ctrl}; trig = tbl[i].trig;
         err = tbl[i].err; step = tbl[i].step; rd = tbl[i].rd;
         cyc();
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].vld));
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("tbl%0d_ovf", i),   32'(ovf),   32'(tbl[i].ovf));
         if (tbl[i].chk_data) begin
            chk($sformatf("tbl%0d_err", i),  rd_err,  tbl[i].e_err);
            chk($sformatf("tbl%0d_step", i), rd_step, tbl[i].e_step);
         end
      end
      rd = 1'b0; trig = 1'b0;

      // Decimation: dec 2, len 3, trigs 0..8 keep 0,3,6
      ctrl = 32'd0; dec = 32'd2; len = 32'd3; cyc();
      ctrl = 32'd1; cyc();
      chk("dec_arm_state", 32'(state), 32'd1);
      for (int k = 0; k < 9; k++) begin
         trig = 1'b1; err = k; step = -k; cyc();
      end
      trig = 1'b0; cyc();
      chk("dec_count", 32'(count), 32'd3);
      chk("dec_state", 32'(state), 32'd2);
      rd = 1'b1;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("dec_err%0d", j),  rd_err,  32'(3*j));
         chk($sformatf("dec_step%0d", j), rd_step, 32'(-3*j));
         cyc();
      end
      rd = 1'b0;
      chk("dec_drain_count", 32'(count), 32'd0);
      chk("dec_drain_state", 32'(state), 32'd0);

      // Continuous overflow: 300 trigs into 256 entries
      ctrl = 32'd0; dec = 32'd0; len = 32'd0; cyc();
      ctrl = 32'd3; cyc();
      for (int i = 0; i < 300; i++) begin
         trig = 1'b1; err = i; step = -i - 7; cyc();
      end
      trig = 1'b0; cyc();
      chk("full_count", 32'(count), 32'd256);
      chk("full_ovf",   32'(ovf),   32'd1);
      chk("full_state", 32'(state), 32'd1);
      chk("full_head",  rd_err,     32'd0);
      chk("full_hstep", rd_step,    32'(-7));

      // Write and pop together while full
      trig = 1'b1; rd = 1'b1; err = 1000; step = -1000; cyc();
      trig = 1'b0;
      chk("wp_count", 32'(count), 32'd256);
      chk("wp_ovf",   32'(ovf),   32'd1);
      chk("wp_head",  rd_err,     32'd1);
      for (int i = 1; i < 256; i++) begin
         if (rd_err !== 32'(i) || rd_step !== 32'(-i - 7))
            chk($sformatf("retain%0d", i), rd_err ^ rd_step, 32'(i) ^ 32'(-i - 7));
         else
            chk($sformatf("retain%0d", i), rd_err, 32'(i));
         cyc();
      end
      chk("tail_err",  rd_err,  32'd1000);
      chk("tail_step", rd_step, 32'(-1000));
      cyc();
      rd = 1'b0;
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(valid), 32'd0);

      // arm and clear edges in one cycle: clear wins
      ctrl = 32'd2; trig = 1'b1; err = 7; step = 7; cyc();
      trig = 1'b0;
      chk("pre_clr_count", 32'(count), 32'd1);
      ctrl = 32'd7; cyc();
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_valid", 32'(valid), 32'd0);
      chk("clr_ovf",   32'(ovf),   32'd0);
      trig = 1'b1; cyc(); cyc();
      trig = 1'b0;
      chk("idle_trig_count", 32'(count), 32'd0);
      ctrl = 32'd2; cyc();
      ctrl = 32'd3; cyc();
      chk("rearm_state", 32'(state), 32'd1);
      chk("rearm_ovf",   32'(ovf),   32'd0);

      // Reset mid-capture with 5 records buffered
      for (int i = 0; i < 5; i++) begin
         trig = 1'b1; err = 20 + i; step = i; cyc();
      end
      trig = 1'b0; cyc();
      chk("mid_count", 32'(count), 32'd5);
      chk("mid_head",  rd_err,     32'd20);
      rst_n = 1'b0; cyc();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);
      chk("rst_err",   rd_err,     32'd0);
      chk("rst_step",  rd_step,    32'd0);
      rst_n = 1'b1; ctrl = 32'd0;

      // Randomized run against the reference model
      rc = 3'b000;
      for (int i = 0; i < 4000; i++) begin
         rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 1499) != 0);
         if ($urandom_range(0, 39) == 0) begin
            if (!rc[0]) rc[1] = 1'($urandom_range(0, 1));
            rc[0] = ~rc[0];
         end
         if ($urandom_range(0, 149) == 0) rc[2] = ~rc[2];
         ctrl = $urandom();
         ctrl[2:0] = rc;
         dec = {16'($urandom()), 16'($urandom_range(0, 3))};
         pick = $urandom_range(0, 9);
         len = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd300 : (pick == 2) ? 32'h1000_0005 :
               32'($urandom_range(1, 12));
         trig = ($urandom_range(0, 2) == 0);
         err  = $urandom();
         step = $urandom();
         rd   = ((i / 400) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         cyc();
         model_edge();
         chk("rnd_count", 32'(count), 32'(m_q.size()));
         chk("rnd_state", 32'(state), 32'(m_state));
         chk("rnd_ovf",   32'(ovf),   32'(m_ovf));
         chk("rnd_valid", 32'(valid), 32'(m_valid_after(m_t)));
         if (m_valid_after(m_t)) begin
            chk("rnd_err",  rd_err,  m_q[0].err);
            chk("rnd_step", rd_step, m_q[0].step);
         end else if (!rst_n) begin
            chk("rnd_rst_err", rd_err, 32'd0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
